// File: rtl/regbank_pkg.sv
// Shared types and constants for the register-bank sequencer: FSM states,
// opcodes, instruction field positions and register-bank addresses.
package regbank_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDW  = 4'h1;
    localparam logic [3:0] OP_JMP  = 4'h2;
    localparam logic [3:0] OP_BZ   = 4'h3;
    localparam logic [3:0] OP_HALT = 4'h4;
    localparam int         OP_ALU_MSB = 3;

    localparam int OP_HI = 23;
    localparam int OP_LO = 20;
    localparam int A_HI  = 19;
    localparam int A_LO  = 15;
    localparam int B_HI  = 14;
    localparam int B_LO  = 9;
    localparam int C_HI  = 8;
    localparam int C_LO  = 3;
    localparam int T_HI  = 19;
    localparam int T_LO  = 12;

    localparam logic [5:0] REG_IN0  = 6'd28;
    localparam logic [5:0] REG_IN1  = 6'd29;
    localparam logic [5:0] REG_OUT0 = 6'd30;
    localparam logic [5:0] REG_OUT1 = 6'd31;
    localparam logic [5:0] REG_W    = 6'd34;
    localparam logic [5:0] NUM_REGS = 6'd35;
    localparam logic [5:0] C_IDLE   = 6'd63;

    typedef struct packed {
        logic       is_alu;
        logic       is_ldw;
        logic       is_jmp;
        logic       is_bz;
        logic       is_halt;
        logic [4:0] a;
        logic [5:0] b;
        logic [5:0] c_safe;
        logic [7:0] target;
        logic [2:0] alu_op;
    } dec_t;

    // Input-port registers and out-of-range indices are never written.
    function automatic logic [5:0] protect_c(input logic [5:0] c);
        if (c == REG_IN0 || c == REG_IN1 || c >= NUM_REGS)
            return C_IDLE;
        return c;
    endfunction

endpackage

// File: rtl/regbank_decode.sv
// Combinational instruction decoder: splits an instruction word into the
// opcode class flags and the operand fields used by the sequencer.
module regbank_decode
    import regbank_pkg::*;
#(
    parameter int INSTR_W = 24
) (
    input  logic [INSTR_W-1:0] i_instr,
    output dec_t               o_dec
);

    logic [3:0] w_op;
    logic       w_unused_rsvd;

    assign w_op          = i_instr[OP_HI:OP_LO];
    assign w_unused_rsvd = ^i_instr[C_LO-1:0];

    assign o_dec.is_alu  = w_op[OP_ALU_MSB];
    assign o_dec.is_ldw  = (w_op == OP_LDW);
    assign o_dec.is_jmp  = (w_op == OP_JMP);
    assign o_dec.is_bz   = (w_op == OP_BZ);
    assign o_dec.is_halt = (w_op == OP_HALT);
    assign o_dec.a       = i_instr[A_HI:A_LO];
    assign o_dec.b       = i_instr[B_HI:B_LO];
    assign o_dec.c_safe  = protect_c(i_instr[C_HI:C_LO]);
    assign o_dec.target  = i_instr[T_HI:T_LO];
    assign o_dec.alu_op  = w_op[2:0];

endmodule

// File: rtl/regbank_sequencer.sv
// Multi-cycle fetch/decode/exec/writeback sequencer driving the register
// bank selects, W-load strobe and ALU opcode from a synchronous program ROM.
module regbank_sequencer
    import regbank_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 24
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RUN,
    input  logic [INSTR_W-1:0] INSTR,
    input  logic               ZERO,
    output logic [PC_W-1:0]    PC,
    output logic [4:0]         A_CTRL,
    output logic [5:0]         B_CTRL,
    output logic [5:0]         C_CTRL,
    output logic               MR,
    output logic [2:0]         ALU_OP,
    output logic               BUSY,
    output logic               HALTED
);

    state_t             r_state;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_ir;
    logic [4:0]         r_a;
    logic [5:0]         r_b;
    logic [5:0]         r_c;
    logic               r_mr;
    logic [2:0]         r_alu_op;
    logic               r_busy;
    logic               r_halted;

    logic [INSTR_W-1:0] w_dec_in;
    logic [PC_W-1:0]    w_pc_inc;
    dec_t               w_dec;

    // EXEC-cycle outputs are registered, so they must be decoded from the ROM
    // data while IR is still being loaded in DECODE.
    assign w_dec_in = (r_state == S_DECODE) ? INSTR : r_ir;
    assign w_pc_inc = r_pc + PC_W'(1);

    regbank_decode #(.INSTR_W(INSTR_W)) u_decode (
        .i_instr (w_dec_in),
        .o_dec   (w_dec)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_pc     <= '0;
            r_ir     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= C_IDLE;
            r_mr     <= 1'b0;
            r_alu_op <= '0;
            r_busy   <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_mr <= 1'b0;
            r_c  <= C_IDLE;
            case (r_state)
                S_IDLE: begin
                    if (RUN) begin
                        r_state <= S_FETCH;
                        r_busy  <= 1'b1;
                    end
                end
                S_FETCH: r_state <= S_DECODE;
                S_DECODE: begin
                    r_ir    <= INSTR;
                    r_state <= S_EXEC;
                    r_mr    <= w_dec.is_ldw;
                    if (w_dec.is_alu) begin
                        r_a      <= w_dec.a;
                        r_b      <= w_dec.b;
                        r_alu_op <= w_dec.alu_op;
                    end
                end
                S_EXEC: begin
                    if (w_dec.is_alu) begin
                        r_c     <= w_dec.c_safe;
                        r_state <= S_WB;
                    end else if (w_dec.is_halt) begin
                        r_state  <= S_HALT;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                    end else begin
                        if (w_dec.is_jmp || (w_dec.is_bz && ZERO))
                            r_pc <= PC_W'(w_dec.target);
                        else
                            r_pc <= w_pc_inc;
                        r_state <= RUN ? S_FETCH : S_IDLE;
                        r_busy  <= RUN;
                    end
                end
                S_WB: begin
                    r_pc    <= w_pc_inc;
                    r_state <= RUN ? S_FETCH : S_IDLE;
                    r_busy  <= RUN;
                end
                S_HALT: ;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign PC     = r_pc;
    assign A_CTRL = r_a;
    assign B_CTRL = r_b;
    assign C_CTRL = r_c;
    assign MR     = r_mr;
    assign ALU_OP = r_alu_op;
    assign BUSY   = r_busy;
    assign HALTED = r_halted;

endmodule

// File: doc/regbank_sequencer.md
Name: regbank_sequencer

Overview:
Multi-cycle control unit that fetches 24-bit instructions from a synchronous program memory and sequences the 35-entry register bank. It drives the bank's A/B read selects, C write select and MR (W-load) strobe, plus an ALU opcode. It sits between the program ROM and the register bank/ALU datapath, and is the only master of A_CTRL/B_CTRL/C_CTRL/MR.

Parameters:
PC_W, 8, program counter / ROM address width
INSTR_W, 24, instruction width
C_IDLE, 6'd63, C_CTRL value meaning "no write" (any value >= 35 is ignored by the bank)

Ports:
CLK  in  1  system clock, all state on rising edge
RST  in  1  synchronous reset, active-high
RUN  in  1  level; 1 = execute, 0 = stop at next instruction boundary
INSTR  in  24  program memory read data, valid one cycle after PC is presented
ZERO  in  1  ALU zero flag, sampled in EXEC
PC  out  PC_W  program memory address
A_CTRL  out  5  register bank read select A
B_CTRL  out  6  register bank read select B
C_CTRL  out  6  register bank write select (C_IDLE = no write)
MR  out  1  one-cycle strobe: load register 34 (W) from TO_W
ALU_OP  out  3  ALU function select
BUSY  out  1  1 whenever state is not IDLE/HALT
HALTED  out  1  1 in HALT state

Behaviour:
- Clock CLK, reset RST: one clock; reset is synchronous and active-high.
- Reset values: PC=0, state=IDLE, IR=0, A_CTRL=0, B_CTRL=0, C_CTRL=C_IDLE, MR=0, ALU_OP=0, BUSY=0, HALTED=0. All outputs are registered.
- Instruction fields: [23:20] OP, [19:15] A, [14:9] B, [8:3] C, [2:0] reserved. Branch target = [19:12].
- OP decode: OP[3]=1 -> ALU op, ALU_OP=OP[2:0]. 0x0 NOP, 0x1 LDW, 0x2 JMP, 0x3 BZ, 0x4 HALT. 0x5-0x7 are reserved and execute as NOP.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
  - IDLE: stays while RUN=0. On RUN=1 -> FETCH.
  - FETCH: PC is stable. -> DECODE.
  - DECODE: IR<=INSTR. -> EXEC.
  - EXEC, ALU op: A_CTRL=A, B_CTRL=B, ALU_OP driven. -> WB.
  - EXEC, LDW: MR=1 for exactly this cycle; PC<=PC+1.
  - EXEC, JMP: PC<=target.
  - EXEC, BZ: PC<=target if ZERO=1, else PC+1.
  - EXEC, NOP/reserved: PC<=PC+1.
  - EXEC, HALT: -> HALT; PC is not incremented.
  - WB: C_CTRL=C for exactly one cycle. A/B/ALU_OP are held from EXEC. PC<=PC+1.
- Instruction boundary (end of EXEC for non-ALU ops, end of WB for ALU ops): RUN=1 -> FETCH, RUN=0 -> IDLE.
- Cycle counts: ALU op = 4 cycles; all other ops = 3 cycles.
- C_CTRL equals C_IDLE in every state except WB.
- Write protection: a C field of 28 or 29 (input-port registers) or >= 35 is forced to C_IDLE in WB. No write occurs; the sequence otherwise proceeds normally.
- MR is never asserted outside EXEC of LDW. MR and a C write never occur in the same cycle.
- PC wraps 255 -> 0 without any flag.
- HALT: sticky; only RST exits it. RUN is ignored while halted.
- RST mid-instruction: at that edge C_CTRL->C_IDLE and MR->0, so no bank write is issued on the following edge. The partially executed instruction is abandoned.
- RUN dropping mid-instruction does not abort the instruction. It completes, then the sequencer parks in IDLE with PC pointing at the next instruction.

Decomposition:
- Shared package regbank_pkg holds:
  - state enum
  - OP codes (OP_NOP, OP_LDW, OP_JMP, OP_BZ, OP_HALT, OP_ALU_MSB)
  - field bit positions
  - REG_IN0=28, REG_IN1=29, REG_OUT0=30, REG_OUT1=31, REG_W=34, NUM_REGS=35
  - C_IDLE
- One sub-module is natural: regbank_decode, a combinational IR -> {is_alu, is_ldw, is_jmp, is_bz, is_halt, a, b, c_safe, target, alu_op}. The FSM and PC stay in the top.

Test Plan:
- Reset then RUN=1; ROM[0]=OP 0x9, A=3, B=5, C=7 -> A_CTRL=3, B_CTRL=5, ALU_OP=1 in cycle 3; C_CTRL=7 only in cycle 4; PC=1 afterwards.
- ROM[0]=LDW -> MR=1 for exactly one cycle (EXEC); C_CTRL stays 63 throughout; PC=1.
- ROM[0]=BZ target 0x40: with ZERO=1 PC becomes 0x40; with ZERO=0 PC becomes 1. ROM[1]=JMP 0xFF, ROM[0xFF]=NOP -> PC wraps to 0x00.
- ALU op with C=28, then with C=40 -> C_CTRL stays 63 in WB in both cases; PC still increments.
- ROM[2]=HALT -> HALTED=1 and BUSY=0 with PC=2; RUN toggling has no effect; RST -> PC=0, state IDLE.
- RUN dropped during DECODE of an ALU op -> the op completes (WB write occurs), then IDLE with PC=next. RST asserted in EXEC of an ALU op -> no C write on the next edge, all outputs at reset values.
